irq_pending_latch: RTL

Captures six interrupt source lines, latches them into a pending register and masks them. It then presents the highest-priority enabled source to the core through a request/acknowledge handshake. The block sits directly upstream of the six-input OR that forms the core's single interrupt line: its six `Masked_pending` bits drive that OR's six inputs.

---
 rtl/irq_pending_latch_pkg.sv | 24 ++
 rtl/irq_pending_latch_if.sv | 25 ++
 rtl/irq_pending_latch_frontend.sv | 41 ++++
 rtl/irq_pending_latch.sv | 89 ++++++++
 4 files changed

// File: rtl/irq_pending_latch_pkg.sv
// rtl/irq_pending_latch_pkg.sv - shared sizes, FSM encoding and priority helper for irq_pending_latch
package irq_pending_latch_pkg;

    localparam int NUM_SRC = 6;
    localparam int ID_W    = 3;

    // First id that does not name a source; acks at or above it are never valid
    localparam logic [ID_W-1:0] INVALID_ID = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Index 0 is the highest priority, so the lowest set bit wins
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        lowest_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// rtl/irq_pending_latch_if.sv - source, mask and request/acknowledge signals of irq_pending_latch
interface irq_pending_latch_if;
    import irq_pending_latch_pkg::*;

    logic [NUM_SRC-1:0] Irq_in;
    logic [NUM_SRC-1:0] Irq_mask;
    logic               Ack_valid;
    logic [ID_W-1:0]    Ack_id;
    logic [NUM_SRC-1:0] Pending;
    logic [NUM_SRC-1:0] Masked_pending;
    logic               Irq_req;
    logic [ID_W-1:0]    Irq_id;
    logic               Ack_err;

    modport master (
        output Irq_in, Irq_mask, Ack_valid, Ack_id,
        input  Pending, Masked_pending, Irq_req, Irq_id, Ack_err
    );

    modport slave (
        input  Irq_in, Irq_mask, Ack_valid, Ack_id,
        output Pending, Masked_pending, Irq_req, Irq_id, Ack_err
    );

endinterface

// File: rtl/irq_pending_latch_frontend.sv
// rtl/irq_pending_latch_frontend.sv - irq_src_frontend: optional IRQ_SYNC_EN synchronizer, edge/level selection
module irq_src_frontend #(
    parameter int           W         = 6,
    parameter logic [W-1:0] EDGE_MASK = {W{1'b1}}
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic [W-1:0] i_irq,
    output logic [W-1:0] o_s
);

    logic [W-1:0] w_lvl;
    logic [W-1:0] r_prev;

`ifdef IRQ_SYNC_EN
    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = r_sync2;
`else
    assign w_lvl = i_irq;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_prev <= '0;
        else          r_prev <= w_lvl;
    end

    assign o_s = (EDGE_MASK & w_lvl & ~r_prev) | (~EDGE_MASK & w_lvl);

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - pending register, priority pick and request/ack FSM (IRQ_SYNC_EN selects input synchronizer)
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 6'b111111
) (
    input  logic                Clock,
    input  logic                Reset_n,
    irq_pending_latch_if.slave  bus
);

    localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] r_pending;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_irq_id_nxt;
    logic               r_ack_err;
    logic               w_ack_err_nxt;
    logic               w_ack_match;

    irq_src_frontend #(
        .W         (NUM_SRC),
        .EDGE_MASK (EDGE_MASK)
    ) u_frontend (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .i_irq   (bus.Irq_in),
        .o_s     (w_s)
    );

    assign w_masked    = r_pending & bus.Irq_mask;
    assign w_ack_match = (bus.Ack_id < INVALID_ID) && (bus.Ack_id == r_irq_id);

    always_comb begin
        w_state_nxt   = r_state;
        w_irq_id_nxt  = r_irq_id;
        w_ack_err_nxt = 1'b0;
        w_clr         = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_masked) begin
                    w_state_nxt  = ST_REQ;
                    w_irq_id_nxt = lowest_set(w_masked);
                end
            end
            ST_REQ: begin
                if (bus.Ack_valid) begin
                    if (w_ack_match) w_state_nxt   = ST_CLEAR;
                    else             w_ack_err_nxt = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_clr       = ONE_HOT0 << r_irq_id;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_irq_id  <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq_id  <= w_irq_id_nxt;
            r_ack_err <= w_ack_err_nxt;
        end
    end

    // Set is OR-ed after the clear so an edge arriving during CLEAR survives
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_pending <= '0;
        else          r_pending <= (r_pending & ~w_clr) | w_s;
    end

    assign bus.Pending        = r_pending;
    assign bus.Masked_pending = w_masked;
    assign bus.Irq_req        = (r_state == ST_REQ);
    assign bus.Irq_id         = r_irq_id;
    assign bus.Ack_err        = r_ack_err;

endmodule
